// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - PS/2 device-side transmitter with byte FIFO, parity/gap options and host-inhibit abort
module ps2_dev_tx #(
    parameter int FIFO_BITS  = 3,
    parameter bit PARITY_ODD = 1'b1,
    parameter int GAP_CLKS   = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 wr,
    input  logic [7:0]           wr_data,
    input  logic                 inhibit,
    input  logic                 clr_overflow,
    output logic                 ps2_dev_clk,
    output logic                 ps2_dev_data,
    output logic [FIFO_BITS:0]   level,
    output logic                 full,
    output logic                 overflow,
    output logic                 busy,
    output logic                 abort
);

    localparam int                 DEPTH   = 2 ** FIFO_BITS;
    localparam logic [FIFO_BITS:0] DEPTH_L = {1'b1, {FIFO_BITS{1'b0}}};
    localparam logic [3:0]         GAP_L   = 4'(GAP_CLKS);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAR,
        STOP,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic                 s1, s2, s3;
    logic                 rise;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_BITS-1:0] wptr, rptr;
    logic                 push_ok, pop;
    logic [7:0]           shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 data_q, data_d;
    logic [2:0]           bit_q, bit_d;
    logic [3:0]           gap_q, gap_d;
    logic                 abort_d;

    // s3 trails s2 by one cycle so a rising edge shows up as a single-cycle pulse
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= ps2_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // a push is still accepted when full if the head leaves in the same cycle
    assign push_ok = wr & (~full | pop);
    assign full    = (level == DEPTH_L);

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + FIFO_BITS'(1);
            end
            if (pop) begin
                rptr <= rptr + FIFO_BITS'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + (FIFO_BITS + 1)'(1);
                2'b01:   level <= level - (FIFO_BITS + 1)'(1);
                default: level <= level;
            endcase
            if (wr && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= 1'b1;
            bit_q   <= '0;
            gap_q   <= '0;
            abort   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            abort   <= abort_d;
        end
    end

    // inhibit is checked every cycle and outranks rise, so the head byte is never popped by an aborted frame
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && (level != '0) && !inhibit) begin
                    shift_d = mem[rptr];
                    par_d   = PARITY_ODD;
                    data_d  = 1'b0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA, PAR, STOP: begin
                if (inhibit) begin
                    state_d = IDLE;
                    data_d  = 1'b1;
                    abort_d = 1'b1;
                end else if (rise) begin
                    if (state_q == DATA) begin
                        data_d  = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        par_d   = par_q ^ shift_q[0];
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = PAR;
                        end
                    end else if (state_q == PAR) begin
                        data_d  = par_q;
                        state_d = STOP;
                    end else begin
                        data_d  = 1'b1;
                        pop     = 1'b1;
                        gap_d   = GAP_L;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (rise) begin
                    if (gap_q <= 4'd1) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = 1'b1;
            end
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign ps2_dev_clk  = s2 | (state_q == IDLE);
    assign ps2_dev_data = data_q;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb/tb_ps2_dev_tx.sv - randomized self-checking bench for ps2_dev_tx with a frame-level reference model
module tb_ps2_dev_tx;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_run = 1'b0;
    logic       wr      [2] = '{1'b0, 1'b0};
    logic [7:0] wr_data [2] = '{8'h00, 8'h00};
    logic       inhibit [2] = '{1'b0, 1'b0};
    logic       clr_ovf [2] = '{1'b0, 1'b0};
    logic       dclk    [2];
    logic       ddata   [2];
    logic [3:0] level   [2];
    logic       full    [2];
    logic       ovf     [2];
    logic       busy    [2];
    logic       abrt    [2];

    ps2_dev_tx #(.FIFO_BITS(3), .PARITY_ODD(1'b1), .GAP_CLKS(1)) u_dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk),
        .wr(wr[0]), .wr_data(wr_data[0]), .inhibit(inhibit[0]), .clr_overflow(clr_ovf[0]),
        .ps2_dev_clk(dclk[0]), .ps2_dev_data(ddata[0]), .level(level[0]), .full(full[0]),
        .overflow(ovf[0]), .busy(busy[0]), .abort(abrt[0])
    );

    ps2_dev_tx #(.FIFO_BITS(3), .PARITY_ODD(1'b0), .GAP_CLKS(3)) u_dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk),
        .wr(wr[1]), .wr_data(wr_data[1]), .inhibit(inhibit[1]), .clr_overflow(clr_ovf[1]),
        .ps2_dev_clk(dclk[1]), .ps2_dev_data(ddata[1]), .level(level[1]), .full(full[1]),
        .overflow(ovf[1]), .busy(busy[1]), .abort(abrt[1])
    );

    always #5 clk_sys = ~clk_sys;

    int pclk_falls = 0;
    initial begin
        forever begin
            #97;
            if (ps2_run) begin
                ps2_clk = ~ps2_clk;
                if (!ps2_clk) pclk_falls++;
            end else begin
                ps2_clk = 1'b1;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: per-device queue of bytes still owed on the wire
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int k, input logic [7:0] b);
        if (k == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    function automatic logic exp_par(input int k, input logic [7:0] b);
        return (k == 0) ? ~^b : ^b;
    endfunction

    int         nbits   [2] = '{0, 0};
    int         nframes [2] = '{0, 0};
    int         aborts  [2] = '{0, 0};
    logic       prev_dclk [2] = '{1'b1, 1'b1};
    logic [10:0] sr     [2];
    int         starts  [2][256];

    task automatic frame_done(input int k);
        logic [7:0]  b;
        logic [31:0] want;
        b    = sr[k][8:1];
        want = 32'h100;
        if (qsize(k) != 0) want = (k == 0) ? {24'h0, q0[0]} : {24'h0, q1[0]};
        check($sformatf("dev%0d frame byte", k), {24'h0, b}, want);
        check($sformatf("dev%0d parity", k), sr[k][9], exp_par(k, b));
        check($sformatf("dev%0d stop bit", k), sr[k][10], 1);
        if (qsize(k) != 0) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
        nframes[k]++;
    endtask

    // wire-level decoder: sample data on falling edges of the device clock
    always @(negedge clk_sys) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                nbits[k] = 0;
            end else if (abrt[k]) begin
                nbits[k] = 0;
                aborts[k]++;
            end else if (prev_dclk[k] && !dclk[k]) begin
                if (nbits[k] == 0) begin
                    if (ddata[k] == 1'b0) begin
                        nbits[k] = 1;
                        starts[k][nframes[k] % 256] = pclk_falls;
                    end
                end else begin
                    sr[k][nbits[k]] = ddata[k];
                    nbits[k]++;
                    if (nbits[k] == 11) begin
                        frame_done(k);
                        nbits[k] = 0;
                    end
                end
            end
            prev_dclk[k] = dclk[k];
        end
    end

    task automatic push(input int k, input logic [7:0] b);
        @(negedge clk_sys);
        wr[k] = 1'b1;
        wr_data[k] = b;
        @(negedge clk_sys);
        wr[k] = 1'b0;
        if (qsize(k) < 8) q_push(k, b);
    endtask

    task automatic stop_clk();
        ps2_run = 1'b0;
        repeat (30) @(negedge clk_sys);
    endtask

    task automatic wait_bits(input int k, input int n, input int budget, input string tag);
        int i = 0;
        while (nbits[k] < n && i < budget) begin
            @(negedge clk_sys);
            i++;
        end
        check(tag, nbits[k] >= n, 1);
    endtask

    task automatic drain(input int k, input int budget);
        int i = 0;
        while (!(qsize(k) == 0 && !busy[k] && nbits[k] == 0) && i < budget) begin
            @(negedge clk_sys);
            i++;
        end
        check($sformatf("dev%0d drained", k), (qsize(k) == 0) && !busy[k], 1);
        check($sformatf("dev%0d level after drain", k), level[k], 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base, a0, fr0, i;
        logic pv;
        logic [7:0] b;

        repeat (3) @(negedge clk_sys);
        check("reset level", level[0], 0);
        check("reset full", full[0], 0);
        check("reset busy", busy[0], 0);
        check("reset data", ddata[0], 1);
        check("reset clk", dclk[0], 1);
        check("reset overflow", ovf[0], 0);
        check("reset abort", abrt[0], 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        // single byte, odd parity
        push(0, 8'hA5);
        check("level after push", level[0], 1);
        ps2_run = 1'b1;
        drain(0, 3000);

        // overflow with the bit clock stopped
        stop_clk();
        for (int j = 0; j < 9; j++) push(0, 8'($urandom));
        check("burst level", level[0], 8);
        check("burst full", full[0], 1);
        check("burst overflow", ovf[0], 1);
        @(negedge clk_sys);
        wr[0] = 1'b1; wr_data[0] = 8'h77; clr_ovf[0] = 1'b1;
        @(negedge clk_sys);
        wr[0] = 1'b0; clr_ovf[0] = 1'b0;
        check("set beats clear", ovf[0], 1);
        check("dropped push level", level[0], 8);
        @(negedge clk_sys); clr_ovf[0] = 1'b1;
        @(negedge clk_sys); clr_ovf[0] = 1'b0;
        check("overflow cleared", ovf[0], 0);
        base = nframes[0];
        ps2_run = 1'b1;
        drain(0, 6000);
        for (int j = 0; j < 7; j++)
            check("dev0 frame spacing", starts[0][(base + j + 1) % 256] - starts[0][(base + j) % 256], 12);

        // host inhibit mid-frame, then full resend
        push(0, 8'h1C);
        wait_bits(0, 5, 2000, "reach D3");
        a0 = aborts[0];
        @(negedge clk_sys); inhibit[0] = 1'b1;
        i = 0;
        while (aborts[0] == a0 && i < 10) begin
            @(negedge clk_sys);
            i++;
        end
        check("abort pulse", aborts[0] - a0, 1);
        check("inhibit data", ddata[0], 1);
        check("inhibit clk", dclk[0], 1);
        check("inhibit level", level[0], 1);
        repeat (400) @(negedge clk_sys);
        check("inhibit blocks start", busy[0], 0);
        inhibit[0] = 1'b0;
        drain(0, 3000);

        // full FIFO, push lands in the STOP pop cycle
        stop_clk();
        for (int j = 0; j < 8; j++) push(0, 8'($urandom));
        check("refill full", full[0], 1);
        ps2_run = 1'b1;
        wait_bits(0, 10, 3000, "reach stop");
        pv = dclk[0];
        i = 0;
        while (i < 200) begin
            @(negedge clk_sys);
            i++;
            if (dclk[0] && !pv) break;
            pv = dclk[0];
        end
        check("stop rise seen", i < 200, 1);
        b = 8'($urandom);
        wr[0] = 1'b1; wr_data[0] = b;
        @(negedge clk_sys);
        wr[0] = 1'b0;
        q_push(0, b);
        check("push at pop level", level[0], 8);
        check("push at pop overflow", ovf[0], 0);
        drain(0, 6000);

        // even parity and 3-rise gap on the second device
        stop_clk();
        push(1, 8'hFF);
        push(1, 8'h3C);
        base = nframes[1];
        ps2_run = 1'b1;
        drain(1, 3000);
        check("dev1 frame spacing", starts[1][(base + 1) % 256] - starts[1][base % 256], 14);

        // randomized traffic with sporadic inhibits
        for (int it = 0; it < 60; it++) begin
            int k;
            k = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 250)) @(negedge clk_sys);
            if ($urandom_range(0, 7) == 0) begin
                inhibit[k] = 1'b1;
                repeat ($urandom_range(1, 120)) @(negedge clk_sys);
                inhibit[k] = 1'b0;
            end else if (qsize(k) < 6) begin
                push(k, 8'($urandom));
            end
        end
        drain(0, 20000);
        drain(1, 20000);
        check("dev0 no overflow", ovf[0], 0);
        check("dev1 no overflow", ovf[1], 0);

        // reset in the middle of a frame
        push(0, 8'h96);
        push(0, 8'h3B);
        wait_bits(0, 6, 2000, "reach D5");
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check("mid reset data", ddata[0], 1);
        check("mid reset clk", dclk[0], 1);
        check("mid reset level", level[0], 0);
        check("mid reset busy", busy[0], 0);
        q0.delete();
        q1.delete();
        fr0 = nframes[0];
        repeat (5) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (1500) @(negedge clk_sys);
        check("no frame after reset", nframes[0] - fr0, 0);
        check("idle after reset", busy[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
